ahb_lite_cmd_master: RTL
========================

// Module: ahb_lite_cmd_master
// PURPOSE
//  Synthesizable AHB-Lite initiator. Turns single read/write commands from a valid/ready
//  port into pipelined SINGLE transfers on the system bus, in front of the decoder/mux/slaves.
//  Returns one response per command, in order, through a buffered valid/ready port.
//  Used for bus test traffic and as the front end of later DMA/bridge blocks.
// PARAMETERS
//  RSP_DEPTH  4        response FIFO depth and max commands in flight; power of two, >=2
//  HPROT_VAL  4'b0011  constant HPROT value (data access, privileged)
// PORTS
//  HCLK        in   1   system clock; sole clock
//  RESET       in   1   synchronous, active-high reset
//  cmd_valid   in   1   command offered
//  cmd_ready   out  1   command accepted when cmd_valid & cmd_ready at HCLK edge
//  cmd_write   in   1   1=write, 0=read
//  cmd_addr    in   32  byte address
//  cmd_size    in   3   HSIZE encoding; 0/1/2 legal
//  cmd_wdata   in   32  write data, already lane-placed by the caller
//  rsp_valid   out  1   response available (FIFO head)
//  rsp_ready   in   1   response consumed when rsp_valid & rsp_ready
//  rsp_write   out  1   echo of cmd_write
//  rsp_err     out  1   HRESP seen in data phase, or illegal command
//  rsp_rdata   out  32  raw HRDATA for reads; 0 for writes and illegal commands
//  busy        out  1   any command in address phase, data phase or FIFO
//  HADDR/HWRITE/HSIZE  out 32/1/3   address-phase control
//  HTRANS      out  2   IDLE(00) or NONSEQ(10) only
//  HBURST/HPROT/HMASTLOCK  out 3/4/1  constant 3'b000 / HPROT_VAL / 0
//  HWDATA      out  32  data-phase write data
//  HRDATA      in   32  read data;  HREADY in 1 bus ready;  HRESP in 1 error response
// BEHAVIOUR
//  Reset (sync, RESET=1): AP/DP slots and FIFO cleared; HTRANS=IDLE, HADDR=0, HWRITE=0,
//   HSIZE=0, HWDATA=0, cmd_ready=0, rsp_valid=0, busy=0. In-flight responses are dropped.
//  Two slots: AP (address phase, drives HADDR/HWRITE/HSIZE/HTRANS), DP (drives HWDATA).
//  inflight = AP.valid + DP.valid + fifo_count. cmd_ready = HREADY & (inflight < RSP_DEPTH)
//   & ~RESET; FIFO pop in the same cycle does not grant a credit.
//  Edge with HREADY=1: DP<=AP; AP<=accepted command, else AP.valid=0. HREADY=0: AP, DP and
//   all H* outputs held stable.
//  Completion: DP.valid & HREADY at edge -> push {write, err=HRESP|DP.bad, rdata} into FIFO.
//  Illegal command (cmd_size>2, or addr not aligned to size): accepted, AP.bad=1, drives
//   HTRANS=IDLE in its slot, completes as err=1, rdata=0; ordering with neighbours kept.
//  HRESP=1 with HREADY=0 (first error cycle): the next AP transfer is not cancelled.
//  Latency, zero-wait slave: cmd accepted edge N -> NONSEQ in cycle N+1 -> data phase N+2
//   -> rsp_valid from cycle N+3. Full throughput: one transfer per cycle.
//  FIFO full is impossible by credit rule; push and pop in same cycle legal at any count.
//  busy = AP.valid | DP.valid | rsp_valid.
// STRUCTURE
//  ahb_lite_pkg: HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD, HBURST_SINGLE constants;
//   packed struct ahb_rsp_t {write, err, rdata[31:0]}; function size_aligned(addr,size).
//  Sub-module ahb_master_rsp_fifo (ahb_rsp_t, depth RSP_DEPTH, count output, sync reset).
//  Top holds AP/DP registers, credit logic, output drive.
// TESTING
//  1 Write word 0x2000_0010=0xCAFEF00D, HREADY=1 -> NONSEQ/HWRITE=1 one cycle, HWDATA
//    0xCAFEF00D next cycle, rsp_valid write=1 err=0 one cycle later.
//  2 Three reads 0x0,0x4,0x8 back-to-back, HREADY=1, slave returns 0x11/0x22/0x33 -> three
//    consecutive NONSEQ cycles, responses 0x11,0x22,0x33 in order.
//  3 Two writes, slave HREADY=0 for 2 cycles in first data phase -> second HADDR/HWRITE and
//    first HWDATA stable, cmd_ready=0 through stall, both complete err=0.
//  4 rsp_ready=0, RSP_DEPTH=4, 6 reads offered -> exactly 4 accepted, then HTRANS=IDLE;
//    rsp_ready=1 -> remaining 2 issued, 6 responses in order.
//  5 Word read 0x0000_0002 between two legal reads -> no NONSEQ for it, rsp err=1 rdata=0,
//    neighbour responses unaffected; HRESP=1 two-cycle error on a read -> rsp_err=1.
//  6 RESET=1 for one cycle with AP and DP occupied -> next cycle HTRANS=IDLE, busy=0,
//    rsp_valid=0; new command afterwards completes normally.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, response record and alignment helper.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef struct packed {
    logic        write;
    logic        err;
    logic [31:0] rdata;
  } ahb_rsp_t;

  // True when size is a legal encoding (byte/half/word) and addr is naturally aligned to it.
  function automatic logic size_aligned(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] mask;
    logic        legal;
    legal = 1'b1;
    mask  = '0;
    case (size)
      HSIZE_BYTE: mask = 32'd0;
      HSIZE_HALF: mask = 32'd1;
      HSIZE_WORD: mask = 32'd3;
      default:    legal = 1'b0;
    endcase
    return legal && ((addr & mask) == 32'd0);
  endfunction

endpackage

// File: rtl/ahb_lite_cmd_master_if.sv
// Command, response and AHB-Lite bus signals of the command master.
interface ahb_lite_cmd_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  logic        busy;

  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
           HRDATA, HREADY, HRESP,
    output cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata, busy,
           HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
           HRDATA, HREADY, HRESP,
    input  cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata, busy,
           HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HMASTLOCK, HWDATA
  );

endinterface

// File: rtl/ahb_master_rsp_fifo.sv
// In-order response FIFO; the master's credit rule keeps it from ever overflowing.
module ahb_master_rsp_fifo
  import ahb_lite_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ahb_rsp_t                 push_data,
  input  logic                     pop,
  output ahb_rsp_t                 pop_data,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  ahb_rsp_t           mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]      count_q, count_d;
  logic               do_push;
  logic               do_pop;

  // Qualify push/pop against full/empty and advance pointers and occupancy.
  always_comb begin
    do_push  = push && (count_q != (PtrW + 1)'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data  = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: one SINGLE transfer per command, pipelined address/data phases,
// in-order buffered responses.
module ahb_lite_cmd_master
  import ahb_lite_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 4,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input logic                   HCLK,
  input logic                   RESET,
  ahb_lite_cmd_master_if.master bus
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH) + 2;

  // Address-phase slot.
  logic        ap_valid_q, ap_valid_d;
  logic        ap_bad_q, ap_bad_d;
  logic        ap_write_q, ap_write_d;
  logic [31:0] ap_addr_q, ap_addr_d;
  logic [2:0]  ap_size_q, ap_size_d;
  logic [31:0] ap_wdata_q, ap_wdata_d;

  // Data-phase slot.
  logic        dp_valid_q, dp_valid_d;
  logic        dp_bad_q, dp_bad_d;
  logic        dp_write_q, dp_write_d;
  logic [31:0] dp_wdata_q, dp_wdata_d;

  logic                      cmd_ready;
  logic                      accept;
  logic                      complete;
  logic [CntW-1:0]           inflight;
  logic [$clog2(RSP_DEPTH):0] fifo_count;
  logic                      fifo_not_empty;
  ahb_rsp_t                  push_rsp;
  ahb_rsp_t                  head_rsp;

  // A FIFO pop in the same cycle deliberately does not free a credit.
  assign inflight  = CntW'(ap_valid_q) + CntW'(dp_valid_q) + CntW'(fifo_count);
  assign cmd_ready = bus.HREADY && (inflight < CntW'(RSP_DEPTH)) && !RESET;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign complete  = dp_valid_q && bus.HREADY;

  // Slot advance on HREADY; everything holds while the slave stalls.
  always_comb begin
    ap_valid_d = ap_valid_q;
    ap_bad_d   = ap_bad_q;
    ap_write_d = ap_write_q;
    ap_addr_d  = ap_addr_q;
    ap_size_d  = ap_size_q;
    ap_wdata_d = ap_wdata_q;
    dp_valid_d = dp_valid_q;
    dp_bad_d   = dp_bad_q;
    dp_write_d = dp_write_q;
    dp_wdata_d = dp_wdata_q;
    if (bus.HREADY) begin
      dp_valid_d = ap_valid_q;
      dp_bad_d   = ap_bad_q;
      dp_write_d = ap_write_q;
      dp_wdata_d = (ap_valid_q && ap_write_q && !ap_bad_q) ? ap_wdata_q : '0;
      if (accept) begin
        ap_valid_d = 1'b1;
        ap_bad_d   = !size_aligned(bus.cmd_addr, bus.cmd_size);
        ap_write_d = bus.cmd_write;
        ap_addr_d  = bus.cmd_addr;
        ap_size_d  = bus.cmd_size;
        ap_wdata_d = bus.cmd_wdata;
      end else begin
        // HADDR/HSIZE keep their last value; only the transfer qualifiers drop.
        ap_valid_d = 1'b0;
        ap_bad_d   = 1'b0;
        ap_write_d = 1'b0;
        ap_wdata_d = '0;
      end
    end
  end

  // Slot registers with synchronous reset; in-flight work is discarded.
  always_ff @(posedge HCLK) begin
    if (RESET) begin
      ap_valid_q <= 1'b0;
      ap_bad_q   <= 1'b0;
      ap_write_q <= 1'b0;
      ap_addr_q  <= '0;
      ap_size_q  <= '0;
      ap_wdata_q <= '0;
      dp_valid_q <= 1'b0;
      dp_bad_q   <= 1'b0;
      dp_write_q <= 1'b0;
      dp_wdata_q <= '0;
    end else begin
      ap_valid_q <= ap_valid_d;
      ap_bad_q   <= ap_bad_d;
      ap_write_q <= ap_write_d;
      ap_addr_q  <= ap_addr_d;
      ap_size_q  <= ap_size_d;
      ap_wdata_q <= ap_wdata_d;
      dp_valid_q <= dp_valid_d;
      dp_bad_q   <= dp_bad_d;
      dp_write_q <= dp_write_d;
      dp_wdata_q <= dp_wdata_d;
    end
  end

  // Completed data phase becomes a response; writes and illegal commands return zero data.
  always_comb begin
    push_rsp.write = dp_write_q;
    push_rsp.err   = bus.HRESP || dp_bad_q;
    push_rsp.rdata = (dp_write_q || dp_bad_q) ? 32'd0 : bus.HRDATA;
  end

  ahb_master_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (HCLK),
    .rst       (RESET),
    .push      (complete),
    .push_data (push_rsp),
    .pop       (fifo_not_empty && bus.rsp_ready),
    .pop_data  (head_rsp),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  // Illegal commands occupy their slot but never show NONSEQ on the bus.
  assign bus.HTRANS    = (ap_valid_q && !ap_bad_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = ap_addr_q;
  assign bus.HWRITE    = ap_write_q;
  assign bus.HSIZE     = ap_size_q;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = dp_wdata_q;

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = fifo_not_empty;
  assign bus.rsp_write = head_rsp.write;
  assign bus.rsp_err   = head_rsp.err;
  assign bus.rsp_rdata = head_rsp.rdata;
  assign bus.busy      = ap_valid_q || dp_valid_q || fifo_not_empty;

endmodule
